// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the FFT stage sequencer: state encoding and counter widths.
package fft_stage_sequencer_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IN   = 2'd1,
    ST_SS   = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_watchdog.sv
// Busy-state watchdog: counts cycles while count is high, saturating at TIMEOUT.
module fft_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Asserted during the TIMEOUT-th counted cycle so a registered flag rises at its end.
  assign expired = count && !clear && (cnt_q >= LIMIT - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences one FFT frame: input load, LOG_N-1 ping-pong stage passes, output drain.
// Handshake: every *_start is a registered one-cycle pulse; the matching *_finished is a one-cycle pulse back.
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int N       = 16,
  parameter int LOG_N   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   b2s_finished,
  input  logic                   ss_finished,
  input  logic                   s2o_finished,
  output logic                   b2s_start,
  output logic                   ss_start,
  output logic [LOG_N-1:0]       ss_index,
  output logic                   ss_mode,
  output logic                   s2o_start,
  output logic                   s2o_bank,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   error,
  output state_t                 dbg_state_o
);

  state_t                 state_q, state_d;
  logic                   b2s_start_q, b2s_start_d;
  logic                   ss_start_q, ss_start_d;
  logic                   s2o_start_q, s2o_start_d;
  logic [LOG_N-1:0]       ss_index_q, ss_index_d;
  logic                   ss_mode_q, ss_mode_d;
  logic                   s2o_bank_q, s2o_bank_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   error_q, error_d;
  logic                   armed_q;
  logic                   mismatch;
  logic                   wd_clear, wd_count, wd_expired;

  fft_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  assign mismatch = (b2s_finished && state_q != ST_IN) ||
                    (ss_finished  && state_q != ST_SS) ||
                    (s2o_finished && state_q != ST_OUT);
  assign wd_count = is_busy(state_q);

  always_comb begin
    state_d       = state_q;
    b2s_start_d   = 1'b0;
    ss_start_d    = 1'b0;
    s2o_start_d   = 1'b0;
    ss_index_d    = ss_index_q;
    ss_mode_d     = ss_mode_q;
    s2o_bank_d    = s2o_bank_q;
    frame_count_d = frame_count_q;
    error_d       = error_q;
    wd_clear      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_clear = 1'b1;
        // armed_q holds off the first edge after reset release.
        if (enable && armed_q) begin
          b2s_start_d = 1'b1;
          state_d     = ST_IN;
        end
      end
      ST_IN: begin
        if (b2s_finished) begin
          wd_clear = 1'b1;
          if (LOG_N == 1) begin
            s2o_start_d = 1'b1;
            s2o_bank_d  = 1'b0;
            state_d     = ST_OUT;
          end else begin
            ss_start_d = 1'b1;
            ss_index_d = '0;
            ss_mode_d  = 1'b0;
            state_d    = ST_SS;
          end
        end
      end
      ST_SS: begin
        if (ss_finished) begin
          wd_clear = 1'b1;
          if (int'(ss_index_q) < LOG_N - 2) begin
            ss_index_d = ss_index_q + LOG_N'(1);
            ss_mode_d  = ~ss_mode_q;
            ss_start_d = 1'b1;
          end else begin
            s2o_bank_d  = ~ss_mode_q;
            s2o_start_d = 1'b1;
            state_d     = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (s2o_finished) begin
          wd_clear      = 1'b1;
          frame_count_d = frame_count_q + FRAME_CNT_W'(1);
          if (enable) begin
            b2s_start_d = 1'b1;
            state_d     = ST_IN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (mismatch || wd_expired) error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      b2s_start_q   <= 1'b0;
      ss_start_q    <= 1'b0;
      s2o_start_q   <= 1'b0;
      ss_index_q    <= '0;
      ss_mode_q     <= 1'b0;
      s2o_bank_q    <= 1'b0;
      frame_count_q <= '0;
      error_q       <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      b2s_start_q   <= b2s_start_d;
      ss_start_q    <= ss_start_d;
      s2o_start_q   <= s2o_start_d;
      ss_index_q    <= ss_index_d;
      ss_mode_q     <= ss_mode_d;
      s2o_bank_q    <= s2o_bank_d;
      frame_count_q <= frame_count_d;
      error_q       <= error_d;
      armed_q       <= 1'b1;
    end
  end

  assign b2s_start   = b2s_start_q;
  assign ss_start    = ss_start_q;
  assign s2o_start   = s2o_start_q;
  assign ss_index    = ss_index_q;
  assign ss_mode     = ss_mode_q;
  assign s2o_bank    = s2o_bank_q;
  assign busy        = is_busy(state_q);
  assign frame_count = frame_count_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: LOG_N=4/TIMEOUT=8 instance plus a LOG_N=1 instance.
module tb_fft_stage_sequencer;
  import fft_stage_sequencer_pkg::*;

  logic clk, rst;
  logic enable, b2s_finished, ss_finished, s2o_finished;
  logic b2s_start, ss_start, ss_mode, s2o_start, s2o_bank, busy, error;
  logic [3:0] ss_index;
  logic [15:0] frame_count;
  state_t state;

  logic en1, b2sf1, ssf1, s2of1;
  logic b2s_start1, ss_start1, ss_mode1, s2o_start1, s2o_bank1, busy1, error1;
  logic [0:0] ss_index1;
  logic [15:0] frame_count1;
  state_t state1;

  int n_pass = 0;
  int n_total = 0;

  fft_stage_sequencer #(.N(16), .LOG_N(4), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .b2s_finished(b2s_finished), .ss_finished(ss_finished), .s2o_finished(s2o_finished),
    .b2s_start(b2s_start), .ss_start(ss_start), .ss_index(ss_index), .ss_mode(ss_mode),
    .s2o_start(s2o_start), .s2o_bank(s2o_bank), .busy(busy), .frame_count(frame_count),
    .error(error), .dbg_state_o(state)
  );

  fft_stage_sequencer #(.N(2), .LOG_N(1), .TIMEOUT(1024)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1),
    .b2s_finished(b2sf1), .ss_finished(ssf1), .s2o_finished(s2of1),
    .b2s_start(b2s_start1), .ss_start(ss_start1), .ss_index(ss_index1), .ss_mode(ss_mode1),
    .s2o_start(s2o_start1), .s2o_bank(s2o_bank1), .busy(busy1), .frame_count(frame_count1),
    .error(error1), .dbg_state_o(state1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver tasks
  task automatic pulse(input int which);
    case (which)
      0: b2s_finished = 1'b1;
      1: ss_finished  = 1'b1;
      default: s2o_finished = 1'b1;
    endcase
    tick();
    b2s_finished = 1'b0;
    ss_finished  = 1'b0;
    s2o_finished = 1'b0;
  endtask

  // Returns the finished pulse 5 cycles after the start, checking the start was one cycle wide.
  task automatic serve(input int which);
    tick();
    n_total++;
    if ({b2s_start, ss_start, s2o_start} !== 3'b000)
      $display("FAIL pulse_width: starts=%b expected 000", {b2s_start, ss_start, s2o_start});
    else n_pass++;
    repeat (3) tick();
    pulse(which);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_total++;
    if ({b2s_start, ss_start, s2o_start, busy, error, ss_mode, s2o_bank, ss_index, frame_count} !== 27'd0 ||
        state !== ST_IDLE)
      $display("FAIL reset_values: outs=%h state=%0d expected 0/IDLE",
               {b2s_start, ss_start, s2o_start, busy, error, ss_mode, s2o_bank, ss_index, frame_count}, state);
    else n_pass++;
    enable = 1'b1;
    tick();
    tick();
    n_total++;
    if (b2s_start !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_hold: b2s_start=%b busy=%b expected 0 0", b2s_start, busy);
    else n_pass++;
  endtask

  task automatic test_frame();
    enable = 1'b1;
    do_reset();
    tick();
    n_total++;
    if (b2s_start !== 1'b0)
      $display("FAIL first_edge_quiet: b2s_start=%b expected 0", b2s_start);
    else n_pass++;
    tick();
    n_total++;
    if (b2s_start !== 1'b1 || state !== ST_IN || busy !== 1'b1)
      $display("FAIL frame_load_start: b2s_start=%b state=%0d busy=%b expected 1 1 1", b2s_start, state, busy);
    else n_pass++;
    serve(0);
    n_total++;
    if ({ss_start, ss_index, ss_mode} !== {1'b1, 4'd0, 1'b0} || state !== ST_SS)
      $display("FAIL pass0: start/idx/mode=%h state=%0d expected 20 2", {ss_start, ss_index, ss_mode}, state);
    else n_pass++;
    serve(1);
    n_total++;
    if ({ss_start, ss_index, ss_mode} !== {1'b1, 4'd1, 1'b1})
      $display("FAIL pass1: start/idx/mode=%h expected 23", {ss_start, ss_index, ss_mode});
    else n_pass++;
    serve(1);
    n_total++;
    if ({ss_start, ss_index, ss_mode} !== {1'b1, 4'd2, 1'b0})
      $display("FAIL pass2: start/idx/mode=%h expected 24", {ss_start, ss_index, ss_mode});
    else n_pass++;
    serve(1);
    n_total++;
    if ({s2o_start, s2o_bank, ss_start} !== 3'b110 || state !== ST_OUT)
      $display("FAIL drain_start: s2o_start/bank/ss_start=%b state=%0d expected 110 3",
               {s2o_start, s2o_bank, ss_start}, state);
    else n_pass++;
    serve(2);
    n_total++;
    if (frame_count !== 16'd1 || b2s_start !== 1'b1 || state !== ST_IN || error !== 1'b0)
      $display("FAIL frame_done: fc=%0d b2s_start=%b state=%0d error=%b expected 1 1 1 0",
               frame_count, b2s_start, state, error);
    else n_pass++;
  endtask

  task automatic test_wrong_pulse();
    tick();
    tick();
    pulse(1);
    n_total++;
    if (error !== 1'b1 || state !== ST_IN || ss_start !== 1'b0)
      $display("FAIL stray_ss: error=%b state=%0d ss_start=%b expected 1 1 0", error, state, ss_start);
    else n_pass++;
    pulse(0);
    n_total++;
    if (ss_start !== 1'b1 || state !== ST_SS || error !== 1'b1)
      $display("FAIL recover_ss: ss_start=%b state=%0d error=%b expected 1 2 1", ss_start, state, error);
    else n_pass++;
  endtask

  task automatic test_timeout();
    enable = 1'b1;
    do_reset();
    tick();
    tick();
    enable = 1'b0;
    repeat (7) tick();
    n_total++;
    if (error !== 1'b0)
      $display("FAIL timeout_early: error=%b expected 0 after 7 cycles", error);
    else n_pass++;
    tick();
    n_total++;
    if (error !== 1'b1 || busy !== 1'b1 || state !== ST_IN)
      $display("FAIL timeout_fire: error=%b busy=%b state=%0d expected 1 1 1", error, busy, state);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (error !== 1'b1 || state !== ST_IN)
      $display("FAIL timeout_sticky: error=%b state=%0d expected 1 1", error, state);
    else n_pass++;
  endtask

  task automatic test_idle_enable();
    enable = 1'b1;
    do_reset();
    tick();
    tick();
    pulse(0);
    pulse(1);
    pulse(1);
    pulse(1);
    enable = 1'b0;
    pulse(2);
    n_total++;
    if (state !== ST_IDLE || busy !== 1'b0 || frame_count !== 16'd1 || b2s_start !== 1'b0)
      $display("FAIL to_idle: state=%0d busy=%b fc=%0d b2s_start=%b expected 0 0 1 0",
               state, busy, frame_count, b2s_start);
    else n_pass++;
    tick();
    tick();
    enable = 1'b1;
    tick();
    n_total++;
    if (b2s_start !== 1'b1 || state !== ST_IN)
      $display("FAIL idle_restart: b2s_start=%b state=%0d expected 1 1", b2s_start, state);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse(0);
    pulse(1);
    n_total++;
    if (ss_index !== 4'd1 || state !== ST_SS)
      $display("FAIL mid_setup: ss_index=%0d state=%0d expected 1 2", ss_index, state);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({b2s_start, ss_start, s2o_start, busy, error, ss_mode, s2o_bank, ss_index, frame_count} !== 27'd0)
      $display("FAIL mid_reset: outs=%h expected 0",
               {b2s_start, ss_start, s2o_start, busy, error, ss_mode, s2o_bank, ss_index, frame_count});
    else n_pass++;
    tick();
    rst = 1'b0;
    enable = 1'b1;
    tick();
    n_total++;
    if (b2s_start !== 1'b0)
      $display("FAIL mid_release_first: b2s_start=%b expected 0", b2s_start);
    else n_pass++;
    tick();
    n_total++;
    if (b2s_start !== 1'b1)
      $display("FAIL mid_release_second: b2s_start=%b expected 1", b2s_start);
    else n_pass++;
  endtask

  task automatic test_log1();
    enable = 1'b0;
    en1 = 1'b1;
    do_reset();
    tick();
    tick();
    n_total++;
    if (b2s_start1 !== 1'b1 || state1 !== ST_IN)
      $display("FAIL log1_load: b2s_start=%b state=%0d expected 1 1", b2s_start1, state1);
    else n_pass++;
    b2sf1 = 1'b1;
    tick();
    b2sf1 = 1'b0;
    n_total++;
    if ({s2o_start1, s2o_bank1, ss_start1} !== 3'b100 || state1 !== ST_OUT)
      $display("FAIL log1_drain: s2o_start/bank/ss_start=%b state=%0d expected 100 3",
               {s2o_start1, s2o_bank1, ss_start1}, state1);
    else n_pass++;
    en1 = 1'b0;
    s2of1 = 1'b1;
    tick();
    s2of1 = 1'b0;
    n_total++;
    if (frame_count1 !== 16'd1 || state1 !== ST_IDLE || error1 !== 1'b0)
      $display("FAIL log1_done: fc=%0d state=%0d error=%b expected 1 0 0", frame_count1, state1, error1);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    b2s_finished = 1'b0;
    ss_finished = 1'b0;
    s2o_finished = 1'b0;
    en1 = 1'b0;
    b2sf1 = 1'b0;
    ssf1 = 1'b0;
    s2of1 = 1'b0;
    test_reset();
    test_frame();
    test_wrong_pulse();
    test_timeout();
    test_idle_enable();
    test_reset_mid();
    test_log1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, meaning FFT length (power of two, N >= 2).
REQ-002 SHALL have parameter LOG_N, default 4, meaning log2(N), the number of butterfly stages.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum cycles allowed in any busy state.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  allows a new frame to start.
REQ-007 SHALL have port b2s_finished  input  1  one-cycle pulse: input buffer-to-stage load done.
REQ-008 SHALL have port ss_finished  input  1  one-cycle pulse: stage-to-stage pass done.
REQ-009 SHALL have port s2o_finished  input  1  one-cycle pulse: stage-to-output drain done.
REQ-010 SHALL have port b2s_start  output  1  one-cycle pulse starting a load.
REQ-011 SHALL have port ss_start  output  1  one-cycle pulse starting a pass.
REQ-012 SHALL have port ss_index  output  LOG_N  stage index of the current pass.
REQ-013 SHALL have port ss_mode  output  1  pass direction: 0 = bank A to B, 1 = bank B to A.
REQ-014 SHALL have port s2o_start  output  1  one-cycle pulse starting the drain.
REQ-015 SHALL have port s2o_bank  output  1  bank to drain: 0 = A, 1 = B.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port frame_count  output  16  number of completed frames, wrapping.
REQ-018 SHALL have port error  output  1  sticky control error flag.

Function
REQ-019 SHALL implement states IDLE, IN, SS, OUT.
REQ-020 In IDLE with enable=1, SHALL pulse b2s_start on the next edge and enter IN.
REQ-021 In IN, on b2s_finished, SHALL on the next edge:
- pulse ss_start;
- set ss_index=0 and ss_mode=0;
- enter SS.
REQ-022 If LOG_N=1, REQ-021 SHALL instead pulse s2o_start with s2o_bank=0 and enter OUT.
REQ-023 In SS, on ss_finished with ss_index < LOG_N-2, SHALL on the next edge:
- increment ss_index;
- toggle ss_mode;
- pulse ss_start.
REQ-024 In SS, on ss_finished with ss_index = LOG_N-2, SHALL on the next edge:
- set s2o_bank = ~ss_mode;
- pulse s2o_start;
- enter OUT.
REQ-025 In OUT, on s2o_finished, SHALL increment frame_count (wrapping 0xFFFF to 0), then:
- with enable=1: pulse b2s_start and enter IN on the same edge;
- with enable=0: enter IDLE.
REQ-026 Each start pulse SHALL be exactly one cycle wide and registered, appearing one cycle after the finished pulse that triggered it.
REQ-027 A finished pulse that does not match the current state SHALL set error and SHALL NOT change state.
- Applies even when it coincides with a matching pulse.
- The matching pulse is still acted upon.
REQ-028 A watchdog counter SHALL clear on every state entry and count cycles spent in IN, SS or OUT; reaching TIMEOUT SHALL set error, with state unchanged and the counter saturated.
REQ-029 error SHALL remain high until reset.
REQ-030 ss_index, ss_mode and s2o_bank SHALL be held stable between their updates.

Reset
REQ-031 While rst=1, SHALL force:
- state IDLE;
- all start pulses 0;
- ss_index=0, ss_mode=0, s2o_bank=0;
- busy=0, frame_count=0, error=0;
- watchdog=0.
REQ-032 Reset asserted mid-frame SHALL abort immediately; no start pulse SHALL be emitted while rst=1 or on the first edge after release.

Structure
REQ-033 State encodings and the frame_count width constant SHALL live in the shared fft package.
REQ-034 The watchdog SHALL be one sub-module, fft_watchdog (parameter TIMEOUT; inputs clear and count; output expired); the state machine SHALL be inline.

Verification
REQ-035 LOG_N=4, enable=1, each finished pulse returned 5 cycles after its start:
- sequence b2s_start, ss_start x3 (ss_index 0,1,2; ss_mode 0,1,0), s2o_start with s2o_bank=1;
- frame_count=1, then b2s_start again.
REQ-036 LOG_N=1: b2s_finished -> s2o_start with s2o_bank=0, no ss_start; s2o_finished -> frame_count=1.
REQ-037 ss_finished pulsed while in IN -> error=1 and state stays IN; a later b2s_finished still advances to SS.
REQ-038 TIMEOUT=8, no finished returned after b2s_start -> error=1 exactly 8 cycles after IN entry; busy stays 1.
REQ-039 enable=0 at s2o_finished -> IDLE, busy=0; raising enable -> b2s_start one cycle later.
REQ-040 rst asserted during SS with ss_index=1 -> outputs at reset values immediately; after release with enable=1, first b2s_start on the second edge.
